// File: rtl/proj1_cnt_pkg.sv
// Shared constants for the proj1 counter stream master: FSM state encoding and count direction.
package proj1_cnt_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

    localparam logic MODE_UP = 1'b0;
    localparam logic MODE_DN = 1'b1;
endpackage

// File: rtl/proj1_beat_gen.sv
// Counter datapath: latches a command, steps the data value per accepted beat and flags the last beat.
module proj1_beat_gen
    import proj1_cnt_pkg::*;
#(
    parameter int DATABIT = 7,
    parameter int CNTBIT  = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_load,
    input  logic               i_adv,
    input  logic [CNTBIT-1:0]  i_len,
    input  logic [DATABIT-1:0] i_start,
    input  logic [DATABIT-1:0] i_step,
    input  logic               i_mode,
    output logic [DATABIT-1:0] o_data,
    output logic               o_last
);
    logic [DATABIT-1:0] r_data;
    logic [DATABIT-1:0] r_step;
    logic [CNTBIT-1:0]  r_cnt;
    logic [CNTBIT-1:0]  r_len;
    logic               r_mode;
    logic [DATABIT-1:0] w_data_next;

    // Wraps modulo 2^DATABIT; carry and borrow are dropped by the width.
    assign w_data_next = (r_mode == MODE_UP) ? (r_data + r_step) : (r_data - r_step);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
            r_step <= '0;
            r_cnt  <= '0;
            r_len  <= '0;
            r_mode <= MODE_UP;
        end else if (i_load) begin
            r_data <= i_start;
            r_step <= i_step;
            r_cnt  <= '0;
            r_len  <= i_len;
            r_mode <= i_mode;
        end else if (i_adv) begin
            r_cnt  <= r_cnt + CNTBIT'(1);
            r_data <= w_data_next;
        end
    end

    assign o_data = r_data;
    // Only consulted in RUN, where len is at least 1.
    assign o_last = (r_cnt == (r_len - CNTBIT'(1)));
endmodule

// File: rtl/proj1_cnt_stream_master.sv
// Command-driven counter master: one valid/ready command in, len counter beats out, then a done pulse.
module proj1_cnt_stream_master
    import proj1_cnt_pkg::*;
#(
    parameter int DATABIT = 7,
    parameter int CNTBIT  = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [CNTBIT-1:0]  s_len,
    input  logic [DATABIT-1:0] s_start,
    input  logic [DATABIT-1:0] s_step,
    input  logic               s_mode,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DATABIT-1:0] m_data,
    output logic               m_last,
    output logic               o_busy,
    output logic               o_done
);
    state_t r_state;
    logic   w_load;
    logic   w_adv;
    logic   w_last;

    assign w_load = (r_state == IDLE) && s_valid;
    // The final beat does not advance, so m_data keeps the last value after the run.
    assign w_adv  = (r_state == RUN) && m_ready && !w_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        r_state <= (s_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (m_ready && w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    proj1_beat_gen #(
        .DATABIT (DATABIT),
        .CNTBIT  (CNTBIT)
    ) u_beat_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_adv   (w_adv),
        .i_len   (s_len),
        .i_start (s_start),
        .i_step  (s_step),
        .i_mode  (s_mode),
        .o_data  (m_data),
        .o_last  (w_last)
    );

    assign s_ready = (r_state == IDLE);
    assign m_valid = (r_state == RUN);
    assign m_last  = (r_state == RUN) && w_last;
    assign o_busy  = (r_state == RUN);
    assign o_done  = (r_state == DONE);
endmodule

// File: tb/tb_proj1_cnt_stream_master.sv
// Randomised bench for proj1_cnt_stream_master against a per-command beat-sequence model.
module tb_proj1_cnt_stream_master;
    localparam int DATABIT = 7;
    localparam int CNTBIT  = 7;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               s_valid;
    logic               s_ready;
    logic [CNTBIT-1:0]  s_len;
    logic [DATABIT-1:0] s_start;
    logic [DATABIT-1:0] s_step;
    logic               s_mode;
    logic               m_valid;
    logic               m_ready;
    logic [DATABIT-1:0] m_data;
    logic               m_last;
    logic               o_busy;
    logic               o_done;

    int n_tests = 0;
    int n_fail  = 0;
    int nxt_len, nxt_start, nxt_step, nxt_mode;

    always #5 clk = ~clk;

    proj1_cnt_stream_master #(
        .DATABIT (DATABIT),
        .CNTBIT  (CNTBIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_len   (s_len),
        .s_start (s_start),
        .s_step  (s_step),
        .s_mode  (s_mode),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Beat k of a command is start +/- k*step, reduced modulo 2^DATABIT.
    function automatic int exp_beat(input int start, input int step, input int mode, input int k);
        int v;
        v = (mode != 0) ? (start - k * step) : (start + k * step);
        return v & ((1 << DATABIT) - 1);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_s_ready"}, s_ready, 1);
        check_val({tag, "_m_valid"}, m_valid, 0);
        check_val({tag, "_m_last"},  m_last,  0);
        check_val({tag, "_m_data"},  m_data,  0);
        check_val({tag, "_busy"},    o_busy,  0);
        check_val({tag, "_done"},    o_done,  0);
    endtask

    // Called aligned to a falling edge; returns aligned to a falling edge in the IDLE cycle after DONE.
    task automatic run_cmd(input int len, input int start, input int step, input int mode,
                           input int stall_beat, input int stall_cycles, input int stall_pct,
                           input bit hold_next);
        int  wait_cyc  = 0;
        int  beat      = 0;
        int  stalls    = 0;
        int  fixed     = 0;
        int  cyc       = 0;
        bit  done_seen = 1'b0;
        while (s_ready !== 1'b1 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_val("cmd_ready", s_ready, 1);
        if (s_ready !== 1'b1) return;
        s_valid = 1'b1;
        s_len   = CNTBIT'(len);
        s_start = DATABIT'(start);
        s_step  = DATABIT'(step);
        s_mode  = mode[0];
        @(negedge clk);
        if (hold_next) begin
            nxt_len   = $urandom_range(1, 4);
            nxt_start = $urandom_range(0, 127);
            nxt_step  = $urandom_range(0, 127);
            nxt_mode  = $urandom_range(0, 1);
            s_len     = CNTBIT'(nxt_len);
            s_start   = DATABIT'(nxt_start);
            s_step    = DATABIT'(nxt_step);
            s_mode    = nxt_mode[0];
        end else begin
            s_valid = 1'b0;
        end
        for (int it = 0; it < 4 * len + 20 && !done_seen; it++) begin
            cyc++;
            if (beat < len) begin
                check_val("beat_valid", m_valid, 1);
                check_val("beat_data",  m_data,  exp_beat(start, step, mode, beat));
                check_val("beat_last",  m_last,  (beat == len - 1) ? 1 : 0);
                check_val("beat_busy",  o_busy,  1);
                check_val("beat_ready", s_ready, 0);
                check_val("beat_done",  o_done,  0);
                if (beat == stall_beat && fixed < stall_cycles) begin
                    m_ready = 1'b0;
                    fixed++;
                    stalls++;
                end else if (stalls < 2 * len + 4 && $urandom_range(0, 99) < stall_pct) begin
                    m_ready = 1'b0;
                    stalls++;
                end else begin
                    m_ready = 1'b1;
                    beat++;
                end
                @(negedge clk);
            end else begin
                check_val("done_pulse", o_done,  1);
                check_val("done_cycle", cyc,     len + stalls + 1);
                check_val("done_valid", m_valid, 0);
                check_val("done_busy",  o_busy,  0);
                check_val("done_ready", s_ready, 0);
                done_seen = 1'b1;
                @(negedge clk);
                check_val("idle_ready", s_ready, 1);
                check_val("idle_done",  o_done,  0);
                check_val("idle_hold",  m_data,
                          (len > 0) ? exp_beat(start, step, mode, len - 1) : start);
            end
        end
        if (!done_seen) check_val("done_timeout", 0, 1);
        $display("[TB] cmd len=%0d start=%0d step=%0d mode=%0d stalls=%0d cycles=%0d",
                 len, start, step, mode, stalls, cyc);
    endtask

    initial begin
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_len   = '0;
        s_start = '0;
        s_step  = '0;
        s_mode  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        run_cmd(5, 3, 2, 0, -1, 0, 0, 1'b0);
        run_cmd(4, 1, 1, 1, -1, 0, 0, 1'b0);
        run_cmd(3, 0, 1, 0, 1, 2, 0, 1'b0);
        run_cmd(0, 5, 5, 0, -1, 0, 0, 1'b0);
        run_cmd(2, 20, 4, 0, -1, 0, 0, 1'b1);
        run_cmd(nxt_len, nxt_start, nxt_step, nxt_mode, -1, 0, 0, 1'b0);

        // Abort a len=6 run while its third beat is on the bus.
        s_valid = 1'b1;
        s_len   = CNTBIT'(6);
        s_start = DATABIT'(10);
        s_step  = DATABIT'(3);
        s_mode  = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("abort_pre_valid", m_valid, 1);
        check_val("abort_pre_data",  m_data,  16);
        #1 reset_n = 1'b0;
        #1 check_idle_outputs("abort_now");
        repeat (2) begin
            @(negedge clk);
            check_val("abort_no_done", o_done, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort_release");
        run_cmd(3, 100, 50, 0, -1, 0, 0, 1'b0);
        run_cmd(127, 0, 1, 0, -1, 0, 10, 1'b0);

        for (int n = 0; n < 25; n++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12);
            run_cmd(len, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 1),
                    -1, 0, 25, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/proj1_cnt_stream_master.md
# proj1_cnt_stream_master

Parametrised command-driven counter master for the proj1 seminar datapath. It accepts one command per transaction over a valid/ready slave port: beat count, start value, step and direction. It then emits that many counter values on a valid/ready master stream, marks the final beat with m_last, and pulses o_done when finished. It honours downstream backpressure, handles zero-length commands, and supports up and down counting with wrap-around.

## Interface
- DATABIT, 7: width of start, step and m_data.
- CNTBIT, 7: width of s_len (beat count), so the maximum length is 2^CNTBIT-1.
- clk  in  1  clock, rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  command valid.
- s_ready  out  1  command ready; high only in IDLE.
- s_len  in  CNTBIT  number of beats to emit; 0 is legal.
- s_start  in  DATABIT  value of the first beat.
- s_step  in  DATABIT  increment between beats, unsigned.
- s_mode  in  1  0 = count up (add step), 1 = count down (subtract step).
- m_valid  out  1  stream beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATABIT  current beat value.
- m_last  out  1  high with m_valid on the final beat only.
- o_busy  out  1  high in RUN.
- o_done  out  1  one-cycle pulse in DONE.

## Operation
- FSM states are one-hot: IDLE=3'b001, RUN=3'b010, DONE=3'b100. Any illegal encoding returns to IDLE on the next clock.
- IDLE:
  - s_ready=1.
  - On s_valid&&s_ready, latch s_len, s_step and s_mode. Load the data register with s_start and clear the beat counter.
  - If s_len==0, go to DONE. Otherwise go to RUN.
- RUN:
  - m_valid=1 and m_data=data register.
  - m_last=1 when beat counter == latched len-1.
  - On m_valid&&m_ready:
    - Not last beat: beat counter +1, and data = data ± step, modulo 2^DATABIT (wrap, no saturation).
    - Last beat: go to DONE.
  - Without m_ready, m_data and m_last hold stable and m_valid stays high. There is no retraction.
- DONE: o_done=1 for one cycle, then return to IDLE unconditionally.
- s_* inputs are ignored outside IDLE, and s_ready=0 there. A command presented during RUN stalls until the block re-enters IDLE.
- m_data is driven from the register at all times. It is meaningful only while m_valid=1, and holds the last beat value after DONE.
- Arithmetic:
  - The beat counter is CNTBIT wide.
  - The last-beat compare uses len-1, which is only ever evaluated when len≥1.
  - The data adder/subtractor is DATABIT wide and the carry/borrow is discarded.

## Timing
- Reset values: FSM=IDLE, s_ready=1, m_valid=0, m_last=0, m_data=0, o_busy=0, o_done=0, and all latched registers 0.
- Reset asserted mid-RUN aborts immediately. m_valid drops asynchronously, no m_last or o_done is produced, and the block is in IDLE after release.
- The command is accepted on edge T (s_valid&&s_ready). From that edge:
  - The first beat is valid after edge T, during cycle T+1.
  - With m_ready held high, one beat per cycle, so beats occupy cycles T+1..T+len.
  - o_done is high in cycle T+len+1.
  - s_ready is high again in cycle T+len+2.
- Each cycle of m_ready=0 during RUN delays every subsequent event by one cycle.
- len=0: no beats, o_done is high in cycle T+1, and s_ready is high in cycle T+2.
- Outputs are combinational from state and registers only. There is no combinational path from m_ready or s_valid to any output.

## Structure
- Shared package proj1_cnt_pkg holds:
  - the state localparams IDLE, RUN and DONE;
  - the mode constants MODE_UP=1'b0 and MODE_DN=1'b1.
- Sub-module proj1_beat_gen holds the datapath: data register, beat counter, step/len/mode latches and the last-beat compare. It is controlled by load and advance strobes from the top-level FSM.

## Test plan
- Basic up-count:
  - Stimulus: reset, then command len=5, start=3, step=2, up, with m_ready=1.
  - Required: m_data 3,5,7,9,11 in 5 consecutive cycles, m_last on 11, o_done 1 cycle later, s_ready high in the following cycle.
- Wrap, down-count:
  - Stimulus: DATABIT=7, command len=4, start=1, step=1, down.
  - Required: m_data 1,0,127,126, m_last on 126.
- Backpressure:
  - Stimulus: len=3, start=0, step=1, with m_ready low for 2 cycles on the second beat.
  - Required: m_data stays 1 and m_valid stays high for 3 cycles, then 2 with m_last, and o_done total 6 cycles after acceptance.
- Zero length:
  - Stimulus: len=0.
  - Required: m_valid never rises, o_done in cycle T+1, s_ready in cycle T+2.
- Command during RUN:
  - Stimulus: s_valid held high with new values through a len=2 run.
  - Required: s_ready=0 and the run is unaffected. The second command is accepted in the first IDLE cycle and its first beat follows one cycle later.
- Reset mid-RUN:
  - Stimulus: assert reset_n=0 during beat 2 of len=6.
  - Required: all outputs at reset values immediately, no o_done, and a fresh command after release runs correctly.
